// File: rtl/centroid_unpack_reader.sv
// Fetches centroid_num packed centroid words from memory, splits each into 7 extended
// coordinates and streams them out over valid/ready. Optional CENTROID_UNPACK_PARITY_EN adds parity check.
module centroid_unpack_reader #(
  parameter int unsigned tc_mode          = 1,
  parameter int unsigned addrWidth        = 8,
  parameter int unsigned dataWidth        = 91,
  parameter int unsigned centroid_num     = 8,
  parameter int unsigned accum_cord_width = 22,
  parameter int unsigned cordinate_width  = 13,
  parameter int unsigned idx_width        = $clog2(centroid_num)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [addrWidth-1:0]        base_addr,
  output logic                        mem_rd_en,
  output logic [addrWidth-1:0]        mem_addr,
  input  logic [dataWidth-1:0]        mem_rd_data,
`ifdef CENTROID_UNPACK_PARITY_EN
  input  logic                        mem_rd_par,
  output logic                        par_err,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [accum_cord_width-1:0] coord_1,
  output logic [accum_cord_width-1:0] coord_2,
  output logic [accum_cord_width-1:0] coord_3,
  output logic [accum_cord_width-1:0] coord_4,
  output logic [accum_cord_width-1:0] coord_5,
  output logic [accum_cord_width-1:0] coord_6,
  output logic [accum_cord_width-1:0] coord_7,
  output logic [idx_width-1:0]        out_index,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFin} state_e;

  state_e                                  state_q, state_d;
  logic [addrWidth-1:0]                    addr_q, addr_d;
  logic [idx_width-1:0]                    idx_q, idx_d;
  logic [idx_width-1:0]                    out_index_q, out_index_d;
  logic                                    valid_q, valid_d;
  logic [6:0][accum_cord_width-1:0]        coord_q, coord_d;
`ifdef CENTROID_UNPACK_PARITY_EN
  logic                                    par_err_q, par_err_d;
`endif

  function automatic logic [accum_cord_width-1:0] extend(input logic [cordinate_width-1:0] f);
    if (tc_mode != 0) begin
      return {{(accum_cord_width - cordinate_width){f[cordinate_width-1]}}, f};
    end
    return {{(accum_cord_width - cordinate_width){1'b0}}, f};
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    valid_d     = valid_q;
    coord_d     = coord_q;
`ifdef CENTROID_UNPACK_PARITY_EN
    par_err_d   = par_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr;
          idx_d   = '0;
          state_d = StReq;
`ifdef CENTROID_UNPACK_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        // Read data lands exactly one cycle after the REQ strobe.
        for (int i = 0; i < 7; i++) begin
          coord_d[i] = extend(mem_rd_data[i*cordinate_width +: cordinate_width]);
        end
        out_index_d = idx_q;
        valid_d     = 1'b1;
        state_d     = StHold;
`ifdef CENTROID_UNPACK_PARITY_EN
        if (^{mem_rd_data, mem_rd_par}) par_err_d = 1'b1;
`endif
      end
      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (idx_q == idx_width'(centroid_num - 1)) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + idx_width'(1);
            addr_d  = addr_q + addrWidth'(1);
            state_d = StReq;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      idx_q       <= '0;
      out_index_q <= '0;
      valid_q     <= 1'b0;
      coord_q     <= '0;
`ifdef CENTROID_UNPACK_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      valid_q     <= valid_d;
      coord_q     <= coord_d;
`ifdef CENTROID_UNPACK_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign mem_rd_en = (state_q == StReq);
  assign mem_addr  = addr_q;
  assign out_valid = valid_q;
  assign out_index = out_index_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign coord_1   = coord_q[0];
  assign coord_2   = coord_q[1];
  assign coord_3   = coord_q[2];
  assign coord_4   = coord_q[3];
  assign coord_5   = coord_q[4];
  assign coord_6   = coord_q[5];
  assign coord_7   = coord_q[6];
`ifdef CENTROID_UNPACK_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_centroid_unpack_reader.sv
// Scoreboard bench: u_dut0 (zero-extend, 8 words) and u_dut1 (sign-extend, 4 words) share a
// memory model; expected reads/beats are queued by stimulus and popped by a negedge monitor.
module tb_centroid_unpack_reader;

  typedef struct packed {
    logic [2:0]       idx;
    logic [6:0][21:0] c;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [90:0] mem [256];

  logic             s0, re0, v0, r0, busy0, done0;
  logic [7:0]       b0, a0;
  logic [90:0]      rd0;
  wire  [6:0][21:0] coords0;
  logic [2:0]       idx0;

  logic             s1, re1, v1, r1, busy1, done1;
  logic [7:0]       b1, a1;
  logic [90:0]      rd1;
  wire  [6:0][21:0] coords1;
  logic [1:0]       idx1;
`ifdef CENTROID_UNPACK_PARITY_EN
  logic pe0, pe1;
`endif

  centroid_unpack_reader #(.tc_mode(0), .centroid_num(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .base_addr(b0), .mem_rd_en(re0), .mem_addr(a0),
    .mem_rd_data(rd0),
`ifdef CENTROID_UNPACK_PARITY_EN
    .mem_rd_par(^rd0), .par_err(pe0),
`endif
    .out_valid(v0), .out_ready(r0),
    .coord_1(coords0[0]), .coord_2(coords0[1]), .coord_3(coords0[2]), .coord_4(coords0[3]),
    .coord_5(coords0[4]), .coord_6(coords0[5]), .coord_7(coords0[6]),
    .out_index(idx0), .busy(busy0), .done(done0)
  );

  centroid_unpack_reader #(.tc_mode(1), .centroid_num(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .base_addr(b1), .mem_rd_en(re1), .mem_addr(a1),
    .mem_rd_data(rd1),
`ifdef CENTROID_UNPACK_PARITY_EN
    .mem_rd_par(^rd1), .par_err(pe1),
`endif
    .out_valid(v1), .out_ready(r1),
    .coord_1(coords1[0]), .coord_2(coords1[1]), .coord_3(coords1[2]), .coord_4(coords1[3]),
    .coord_5(coords1[4]), .coord_6(coords1[5]), .coord_7(coords1[6]),
    .out_index(idx1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    if (re0) rd0 <= mem[a0];
    if (re1) rd1 <= mem[a1];
  end

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic [7:0] aq0[$], aq1[$];
  beat_t      bq0[$], bq1[$];

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  function automatic beat_t all7(input logic [21:0] v, input int i);
    beat_t b;
    b.idx = 3'(i);
    b.c   = {7{v}};
    return b;
  endfunction

  // Monitor: every read address and every accepted beat must match the queued expectation.
  always @(negedge clk) begin
    beat_t e;
    if (re0) begin
      if (aq0.size() == 0) check("rd_addr0_unexpected", {1'b1, a0}, 9'h0);
      else check("rd_addr0", a0, aq0.pop_front());
    end
    if (re1) begin
      if (aq1.size() == 0) check("rd_addr1_unexpected", {1'b1, a1}, 9'h0);
      else check("rd_addr1", a1, aq1.pop_front());
    end
    if (v0 && r0) begin
      if (bq0.size() == 0) check("beat0_unexpected", 1'b1, 1'b0);
      else begin
        e = bq0.pop_front();
        check("beat0", {idx0, coords0}, e);
      end
    end
    if (v1 && r1) begin
      if (bq1.size() == 0) check("beat1_unexpected", 1'b1, 1'b0);
      else begin
        e = bq1.pop_front();
        check("beat1", {1'b0, idx1, coords1}, e);
      end
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle0(input string nm);
    check(nm, {re0, a0, v0, coords0, idx0, busy0, done0}, '0);
  endtask

  task automatic push_basic0();
    for (int n = 0; n < 8; n++) begin
      aq0.push_back(8'h10 + 8'(n));
      bq0.push_back(all7(22'(n + 1), n));
    end
  endtask

  task automatic start0(input logic [7:0] b);
    b0 = b; s0 = 1'b1;
    tick();
    s0 = 1'b0;
  endtask

  // Counts from the cycle after start (1) up to the done cycle.
  task automatic wait_done0(inout int cyc);
    while (!done0 && cyc < 300) begin tick(); cyc++; end
  endtask

  task automatic run_basic0(input string nm);
    int cyc;
    int d;
    d = done_cnt0;
    push_basic0();
    r0 = 1'b1;
    start0(8'h10);
    check({nm, "_rd_en_k1"}, {re0, a0}, {1'b1, 8'h10});
    cyc = 1;
    while (!v0 && cyc < 20) begin tick(); cyc++; end
    check({nm, "_first_valid_lat"}, cyc, 3);
    wait_done0(cyc);
    check({nm, "_done_lat"}, cyc, 25);
    tick();
    check({nm, "_done_once"}, {done0, busy0, 32'(done_cnt0 - d)}, {2'b00, 32'd1});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int d;
    beat_t w;
    rst_n = 1'b0; s0 = 1'b0; s1 = 1'b0; r0 = 1'b0; r1 = 1'b0; b0 = '0; b1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_idle0("reset0");
    check("reset1", {re1, a1, v1, coords1, idx1, busy1, done1}, '0);
    repeat (4) tick();
    check_idle0("idle0_stays");

    // Basic run.
    for (int n = 0; n < 8; n++) mem[8'h10 + 8'(n)] = {7{13'(n + 1)}};
    run_basic0("basic");

    // Backpressure on beat 3.
    d = done_cnt0;
    push_basic0();
    r0 = 1'b1;
    start0(8'h10);
    cyc = 0;
    while (!(v0 && idx0 == 3'd3) && cyc < 50) begin tick(); cyc++; end
    check("bp_reach", {v0, idx0}, {1'b1, 3'd3});
    r0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {v0, re0, idx0, coords0}, {1'b1, 1'b0, 3'd3, {7{22'd4}}});
    end
    r0 = 1'b1;
    tick();
    check("bp_next_rd", {re0, a0, v0}, {1'b1, 8'h14, 1'b0});
    cyc = 0;
    wait_done0(cyc);
    tick();
    check("bp_done_once", done_cnt0 - d, 1);

    // Wrap with extension words.
    mem[8'hFE] = {13'h1000, {5{13'h0123}}, 13'h1FFF};
    mem[8'hFF] = {7{13'h0AAA}};
    mem[8'h00] = {7{13'h1555}};
    mem[8'h01] = {7{13'h0001}};
    for (int j = 0; j < 4; j++) mem[8'h02 + 8'(j)] = {7{13'(j + 5)}};

    w.idx = 3'd0;
    w.c = {22'h001000, {5{22'h000123}}, 22'h001FFF};
    bq0.push_back(w);
    bq0.push_back(all7(22'h000AAA, 1));
    bq0.push_back(all7(22'h001555, 2));
    bq0.push_back(all7(22'h000001, 3));
    for (int j = 0; j < 4; j++) bq0.push_back(all7(22'(j + 5), 4 + j));
    aq0.push_back(8'hFE); aq0.push_back(8'hFF);
    for (int j = 0; j < 6; j++) aq0.push_back(8'(j));
    d = done_cnt0;
    start0(8'hFE);
    cyc = 1;
    wait_done0(cyc);
    check("wrap0_done_lat", cyc, 25);
    tick();
    check("wrap0_done_once", done_cnt0 - d, 1);

    // Sign-extending instance, 4 words, start re-pulsed mid-run.
    w.c = {22'h3FF000, {5{22'h000123}}, 22'h3FFFFF};
    bq1.push_back(w);
    bq1.push_back(all7(22'h000AAA, 1));
    bq1.push_back(all7(22'h3FF555, 2));
    bq1.push_back(all7(22'h000001, 3));
    aq1.push_back(8'hFE); aq1.push_back(8'hFF); aq1.push_back(8'h00); aq1.push_back(8'h01);
    r1 = 1'b1;
    b1 = 8'hFE; s1 = 1'b1;
    tick();
    s1 = 1'b0;
    cyc = 1;
    repeat (3) begin tick(); cyc++; end
    b1 = 8'h40; s1 = 1'b1;
    tick(); cyc++;
    s1 = 1'b0;
    while (!done1 && cyc < 100) begin tick(); cyc++; end
    check("wrap1_done_lat", cyc, 13);
    repeat (6) tick();
    check("wrap1_done_once", {busy1, 32'(done_cnt1)}, {1'b0, 32'd1});
    check("wrap1_coords_kept", {1'b0, idx1, coords1}, all7(22'h000001, 3));

    // Reset during HOLD of beat 2.
    d = done_cnt0;
    for (int n = 0; n < 3; n++) aq0.push_back(8'h10 + 8'(n));
    bq0.push_back(all7(22'd1, 0));
    bq0.push_back(all7(22'd2, 1));
    r0 = 1'b1;
    start0(8'h10);
    cyc = 0;
    while (!(v0 && idx0 == 3'd2) && cyc < 50) begin tick(); cyc++; end
    r0 = 1'b0;
    check("midrst_reach", {v0, idx0}, {1'b1, 3'd2});
    tick();
    rst_n = 1'b0;
    tick();
    check_idle0("midrst_outputs");
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_no_done", done_cnt0 - d, 0);
    check("midrst_queues", {16'(aq0.size()), 16'(bq0.size())}, 32'd0);
    run_basic0("after_rst");

    repeat (3) tick();
    check("final_queues", {16'(aq0.size()), 16'(bq0.size()), 16'(aq1.size()), 16'(bq1.size())},
          64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/centroid_unpack_reader.md
Name: centroid_unpack_reader

Overview:
- Reader-side counterpart of the centroid packing path.
- Walks the centroid memory from a base address and fetches `centroid_num` packed words of `dataWidth` bits.
- Splits each word into 7 coordinate fields of `cordinate_width` bits and extends each field to `accum_cord_width`.
- Streams the result as one 7-coordinate beat per centroid over a valid/ready handshake to the distance/accumulate datapath.

Parameters:
- tc_mode, 0, 1 = sign-extend coordinates (two's complement); 0 = zero-extend.
- addrWidth, 8, centroid memory address width.
- dataWidth, 91, packed centroid word width (7*cordinate_width).
- centroid_num, 8, number of words read per run.
- accum_cord_width, 22, width of each unpacked coordinate output.
- cordinate_width, 13, width of each packed coordinate field.
- idx_width, $clog2(centroid_num), width of out_index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- base_addr  in  addrWidth  first word address, sampled with start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  addrWidth  memory read address.
- mem_rd_data  in  dataWidth  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  coordinate beat valid.
- out_ready  in  1  consumer accepts beat.
- coord_1..coord_7  out  accum_cord_width each  unpacked coordinates; coord_n comes from bits [n*cordinate_width-1:(n-1)*cordinate_width].
- out_index  out  idx_width  centroid number of current beat (0-based).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: clk and rst_n as above; reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - state goes to IDLE;
  - all outputs go to 0: mem_rd_en, mem_addr, out_valid, coord_1..7, out_index, busy, done;
  - internal address and index registers clear.
- Reset mid-run abandons the run with no done pulse. Any in-flight read data is discarded.
- FSM states: IDLE, REQ, WAIT, HOLD, FIN.
- IDLE: on start=1, latch base_addr into the address register, clear index, go to REQ. start is ignored in every other state.
- REQ: mem_rd_en=1 for exactly this cycle, mem_addr=address register. Go to WAIT.
- WAIT: at the end of the cycle:
  - capture mem_rd_data;
  - extend each field to accum_cord_width (sign- or zero-extend per tc_mode);
  - register into coord_1..7, set out_index=index, set out_valid=1;
  - go to HOLD.
- HOLD: out_valid=1. coord_*/out_index stay stable until out_valid && out_ready.
  - On that handshake with index == centroid_num-1: clear out_valid, go to FIN.
  - Otherwise: clear out_valid, increment index and address, go to REQ.
- FIN: done=1 for this cycle only, then go to IDLE.
- Latency: start sampled at edge k gives mem_rd_en high in cycle k+1 and out_valid high from cycle k+3.
  - Minimum 3 cycles per beat with out_ready tied high.
  - A run with out_ready=1 throughout takes 3*centroid_num+1 cycles from start to the done cycle inclusive (excluding the start cycle).
- Address arithmetic is modulo 2^addrWidth: base_addr=8'hFE with centroid_num=4 reads FE, FF, 00, 01.
- mem_rd_en is never asserted outside REQ. Only one read is outstanding at a time.
- out_ready is ignored when out_valid=0. out_ready=1 held throughout is legal.
- coord_* keep the last delivered beat after the run; only reset or the next capture changes them.
- start asserted in the FIN cycle is ignored; a new run needs start in IDLE.

Optional Feature:
- Macro: CENTROID_UNPACK_PARITY_EN.
- When defined:
  - adds input mem_rd_par (1 bit) = even parity over mem_rd_data, valid with the data;
  - adds output par_err (1 bit), reset 0.
  - On a WAIT capture where the XOR of mem_rd_data and mem_rd_par equals 1, par_err goes high and stays high until the next start or reset.
  - The beat is still delivered unchanged.
- When undefined: neither port exists and no parity logic is generated.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1 with start=0 -> all outputs 0, busy=0, mem_rd_en never asserts.
- Basic run, tc_mode=0, centroid_num=8, base_addr=8'h10, memory word n = {7{13'(n+1)}}, out_ready=1 -> addresses 10..17 read in order; beat n has all coords = 22'(n+1) and out_index=n; first out_valid 3 cycles after start; done pulses once, 25 cycles after the start cycle.
- Extension: word with coord_1=13'h1FFF, coord_7=13'h1000 -> tc_mode=1 gives 22'h3FFFFF and 22'h3FF000; tc_mode=0 gives 22'h001FFF and 22'h001000.
- Backpressure: out_ready=0 for 5 cycles on beat 3 -> coord_*/out_index stable, no mem_rd_en during the stall, beat 4 read starts the cycle after acceptance.
- Wrap and ignored start: base_addr=8'hFE, centroid_num=4, start re-pulsed mid-run -> addresses FE, FF, 00, 01; second start ignored; exactly one done.
- Reset mid-run during HOLD of beat 2 -> next cycle all outputs 0 and state IDLE, no done; a fresh start then runs normally from beat 0.
